id_operand_fetch: RTL

- Decode-side reader of the integer register file.
- Drives the two combinational read ports of the regfile and resolves RAW hazards against in-flight EX/MEM/WB results (forwarding, load-use interlock).
- Registers resolved operands into a valid/ready pipeline stage feeding EX.
- Sits between instruction decode and the execute stage of the MIPS core.

---
 rtl/id_operand_fetch.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/id_operand_fetch.sv
// Decode-side operand fetch: regfile read, EX/MEM/WB forwarding, load-use interlock,
// and a valid/ready output register feeding EX.
module id_operand_fetch #(
    parameter logic [31:0] RST_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic        in_use_rs,
    input  logic        in_use_rt,
    input  logic [4:0]  in_dest,
    input  logic        in_wen,
    input  logic        in_is_load,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    input  logic        ex_valid,
    input  logic        ex_wen,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_dest,
    input  logic [31:0] ex_result,
    input  logic        mem_valid,
    input  logic        mem_wen,
    input  logic        mem_data_ok,
    input  logic [4:0]  mem_dest,
    input  logic [31:0] mem_result,
    input  logic        wb_we,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_src1,
    output logic [31:0] out_src2,
    output logic [4:0]  out_dest,
    output logic        out_wen,
    output logic        out_is_load,
    output logic [31:0] stall_cnt
);

    logic [1:0][4:0]  w_src;
    logic [1:0]       w_use;
    logic [1:0][31:0] w_rf;
    logic [1:0][31:0] w_opnd;
    logic [1:0]       w_haz;
    logic             w_hazard;
    logic             w_stall;
    logic             w_accept;

    logic             r_valid;
    logic [31:0]      r_pc;
    logic [31:0]      r_src1;
    logic [31:0]      r_src2;
    logic [4:0]       r_dest;
    logic             r_wen;
    logic             r_is_load;
    logic [31:0]      r_stall_cnt;

    assign rf_raddr1 = in_rs;
    assign rf_raddr2 = in_rt;

    assign w_src = {in_rt, in_rs};
    assign w_use = {in_use_rt, in_use_rs};
    assign w_rf  = {rf_rdata2, rf_rdata1};

    // Youngest producer wins; WB bypass covers the regfile's write-then-read-old window.
    always_comb begin
        w_opnd = '0;
        w_haz  = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (w_src[i] == 5'd0 || !w_use[i]) begin
                w_opnd[i] = '0;
            end else if (ex_valid && ex_wen && ex_dest == w_src[i]) begin
                w_opnd[i] = ex_result;
                w_haz[i]  = ex_is_load;
            end else if (mem_valid && mem_wen && mem_dest == w_src[i]) begin
                w_opnd[i] = mem_result;
                w_haz[i]  = !mem_data_ok;
            end else if (wb_we && wb_waddr == w_src[i]) begin
                w_opnd[i] = wb_wdata;
            end else begin
                w_opnd[i] = w_rf[i];
            end
        end
    end

    // in_ready is built from the hazard term alone so it never depends on in_valid.
    assign w_hazard = |w_haz;
    assign w_stall  = in_valid & w_hazard;
    assign in_ready = flush | (!w_hazard & (!r_valid | out_ready));
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid   <= 1'b0;
            r_pc      <= RST_PC;
            r_src1    <= '0;
            r_src2    <= '0;
            r_dest    <= '0;
            r_wen     <= 1'b0;
            r_is_load <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_pc      <= in_pc;
            r_src1    <= w_opnd[0];
            r_src2    <= w_opnd[1];
            r_dest    <= in_dest;
            r_wen     <= in_wen;
            r_is_load <= in_is_load;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !flush && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign out_valid   = r_valid;
    assign out_pc      = r_pc;
    assign out_src1    = r_src1;
    assign out_src2    = r_src2;
    assign out_dest    = r_dest;
    assign out_wen     = r_wen;
    assign out_is_load = r_is_load;
    assign stall_cnt   = r_stall_cnt;

endmodule
